aes_spi_sequencer: RTL

AES_SPI_SEQUENCER -- requirements
Module: aes_spi_sequencer

---
 rtl/aes_spi_sequencer_if.sv | 12 +
 rtl/aes_spi_sequencer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/aes_spi_sequencer_if.sv
// Byte-exchange handshake between the AES frame sequencer and an SPI master.
// The sequencer side uses the master modport; the SPI engine uses the slave modport.
interface aes_spi_sequencer_if;
    logic       m_start;
    logic [7:0] m_tx;
    logic       m_busy;
    logic       m_done;
    logic [7:0] m_rx;

    modport master (output m_start, output m_tx, input m_busy, input m_done, input m_rx);
    modport slave  (input m_start, input m_tx, output m_busy, output m_done, output m_rx);
endinterface

// File: rtl/aes_spi_sequencer.sv
// Sequences one AES block operation over a byte-wide SPI master: sends the opcode/data/key
// frame, waits for the slave, reads 16 result bytes and compares them with a reference.
module aes_spi_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter int unsigned GAP_CYC     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mode,
    input  logic [1:0]             key_sel,
    input  logic [127:0]           data_in,
    input  logic [255:0]           key,
    input  logic [127:0]           expected,
    input  logic                   slave_ready,
    aes_spi_sequencer_if.master    spi,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [127:0]           result,
    output logic                   match
);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned GW = $clog2(GAP_CYC + 2);

    typedef enum logic [2:0] {
        StIdle, StSend, StWaitRdy, StRecv, StFinish, StErr
    } state_e;

    state_e         state;
    logic           mode_q;
    logic [1:0]     key_sel_q;
    logic [127:0]   data_q;
    logic [255:0]   key_q;
    logic [127:0]   exp_q;
    logic [5:0]     xfer;
    logic [GW-1:0]  gap;
    logic [TW-1:0]  tmo;
    logic           pending;

    logic [7:0]     send_byte;
    logic [7:0]     len_byte;
    logic [5:0]     last_send;
    logic [127:0]   data_sh;
    logic [255:0]   key_sh;
    logic           issue_ok;
    logic           got_done;
    logic           abort;
    logic [6:0]     rx_sh;
    logic [127:0]   rx_mask;
    logic [127:0]   rx_ins;

    always_comb begin
        case (key_sel_q)
            2'b00:   begin len_byte = 8'h10; last_send = 6'd33; end
            2'b01:   begin len_byte = 8'h18; last_send = 6'd41; end
            default: begin len_byte = 8'h20; last_send = 6'd49; end
        endcase
        data_sh   = data_q << {xfer - 6'd1, 3'b000};
        key_sh    = key_q << {xfer - 6'd18, 3'b000};
        send_byte = 8'h00;
        if (xfer == 6'd0)        send_byte = mode_q ? 8'h02 : 8'h01;
        else if (xfer <= 6'd16)  send_byte = data_sh[127:120];
        else if (xfer == 6'd17)  send_byte = len_byte;
        else                     send_byte = key_sh[255:248];
        // gap <= 1 here puts the registered m_start exactly GAP_CYC idle cycles after m_done
        issue_ok = !pending && (gap <= GW'(1)) && !spi.m_busy;
        got_done = pending && spi.m_done;
        abort    = (tmo == TW'(TIMEOUT_CYC - 1)) && !got_done
                   && (state == StSend || state == StRecv
                       || (state == StWaitRdy && !(slave_ready && issue_ok)));
        rx_sh    = {~xfer[3:0], 3'b000};
        rx_mask  = ~(128'hff << rx_sh);
        rx_ins   = {120'd0, spi.m_rx} << rx_sh;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            mode_q      <= 1'b0;
            key_sel_q   <= 2'b00;
            data_q      <= '0;
            key_q       <= '0;
            exp_q       <= '0;
            xfer        <= '0;
            gap         <= '0;
            tmo         <= '0;
            pending     <= 1'b0;
            spi.m_start <= 1'b0;
            spi.m_tx    <= 8'h00;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            result      <= '0;
            match       <= 1'b0;
        end else begin
            spi.m_start <= 1'b0;
            done        <= 1'b0;
            // tmo counts cycles since the last m_done or state change
            tmo         <= tmo + 1'b1;
            if (gap != '0) gap <= gap - 1'b1;
            unique case (state)
                StIdle: begin
                    tmo <= '0;
                    if (start && key_sel == 2'b11) begin
                        state <= StErr;
                        error <= 1'b1;
                        done  <= 1'b1;
                        match <= 1'b0;
                    end else if (start) begin
                        state     <= StSend;
                        busy      <= 1'b1;
                        error     <= 1'b0;
                        mode_q    <= mode;
                        key_sel_q <= key_sel;
                        data_q    <= data_in;
                        key_q     <= key;
                        exp_q     <= expected;
                        result    <= '0;
                        xfer      <= '0;
                        gap       <= '0;
                        tmo       <= TW'(1);
                        if (!spi.m_busy) begin
                            spi.m_start <= 1'b1;
                            spi.m_tx    <= mode ? 8'h02 : 8'h01;
                            pending     <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (got_done) begin
                        pending <= 1'b0;
                        gap     <= GW'(GAP_CYC);
                        tmo     <= TW'(1);
                        xfer    <= xfer + 6'd1;
                        if (xfer == last_send) begin
                            state <= StWaitRdy;
                            xfer  <= '0;
                        end
                    end else if (issue_ok) begin
                        spi.m_start <= 1'b1;
                        spi.m_tx    <= send_byte;
                        pending     <= 1'b1;
                    end
                end
                StWaitRdy: begin
                    if (slave_ready && issue_ok) begin
                        state       <= StRecv;
                        tmo         <= TW'(1);
                        spi.m_start <= 1'b1;
                        spi.m_tx    <= 8'h00;
                        pending     <= 1'b1;
                    end
                end
                StRecv: begin
                    if (got_done) begin
                        pending <= 1'b0;
                        gap     <= GW'(GAP_CYC);
                        tmo     <= TW'(1);
                        xfer    <= xfer + 6'd1;
                        result  <= (result & rx_mask) | rx_ins;
                        if (xfer == 6'd15) begin
                            state <= StFinish;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            tmo   <= '0;
                            match <= ({result[127:8], spi.m_rx} == exp_q);
                        end
                    end else if (issue_ok) begin
                        spi.m_start <= 1'b1;
                        spi.m_tx    <= 8'h00;
                        pending     <= 1'b1;
                    end
                end
                StFinish, StErr: begin
                    state <= StIdle;
                    tmo   <= '0;
                    xfer  <= '0;
                    gap   <= '0;
                end
                default: state <= StIdle;
            endcase
            if (abort) begin
                state       <= StErr;
                error       <= 1'b1;
                done        <= 1'b1;
                match       <= 1'b0;
                busy        <= 1'b0;
                pending     <= 1'b0;
                spi.m_start <= 1'b0;
                tmo         <= '0;
            end
        end
    end
endmodule
